pulse_sequencer: RTL and testbench
==================================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 SHALL have parameters: BRAM_ADDR_WIDTH, default 10, instruction memory word address width; PULSE_WIDTH, default 32 (range 1..48), pulse output width; STACK_DEPTH, default 8 (range 2..16), call-stack entries; BRAM_DATA_WIDTH, fixed 64, instruction width.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: S_AXI_ACLK in 1 (clock); S_AXI_ARESETN in 1 (asynchronous active-low reset).
REQ-003 SHALL have these ports:
- cfg in 1: run enable.
- bram_porta_clk out 1: equals S_AXI_ACLK.
- bram_porta_rst out 1: equals ~S_AXI_ARESETN.
- bram_porta_addr out BRAM_ADDR_WIDTH: fetch address.
- bram_porta_rddata in 64: instruction word.
- pc out 32: zero-extended program counter.
- pulse out PULSE_WIDTH: pulse channels.
- tx_offset out 16: TX offset.
- grad_offset out 16: gradient offset.
- running out 1: the sequencer is in any state other than IDLE, HALTED or ERROR.
- halted out 1: the sequencer is in HALTED.
- err out 1: the sequencer is in ERROR.
- err_code out 2: 1 = illegal opcode, 2 = stack overflow, 3 = stack underflow.

Function
REQ-004 SHALL decode the instruction as op=[63:58], r=[57:56] (selects one of four 32-bit counters C0..C3), addr=[BRAM_ADDR_WIDTH-1:0], imm32=[31:0], imm16=[15:0].
REQ-005 SHALL implement this FSM:
- IDLE -> FETCH on cfg=1.
- FETCH -> W1 -> W2 -> EXEC. FETCH drives bram_porta_addr=pc; the BRAM read latency is 2, so the instruction register captures rddata in W2.
- EXEC -> FETCH, DELAY, HALTED or ERROR.
REQ-006 SHALL take 4 cycles for every non-delay instruction, counted from FETCH to the next FETCH.
REQ-007 SHALL execute these opcodes, each advancing pc=pc+1 unless stated otherwise:
- 0x00 NOP.
- 0x01 DEC: Cr=Cr-1, wrapping modulo 2^32.
- 0x02 INC: Cr=Cr+1, wrapping.
- 0x03 LD: Cr=imm32.
- 0x08 TXOFFSET: tx_offset=imm16.
- 0x09 GRADOFFSET: grad_offset=imm16.
- 0x10 JNZ: if Cr!=0 then pc=addr, else pc+1.
- 0x17 J: pc=addr.
- 0x18 CALL: push pc+1, then pc=addr.
- 0x19 RET: pc=pop.
- 0x1C PD: pulse=instr[PULSE_WIDTH-1:0] in EXEC, then DELAY for Cr cycles.
- 0x1F HALT.
REQ-008 SHALL enter ERROR with err_code=1 on any other opcode; pc is not advanced.
REQ-009 SHALL handle PD delays as follows: Cr=0 goes straight to FETCH; otherwise the sequencer stays in DELAY exactly Cr cycles with an internal down-counter. Cr itself is not modified.
REQ-010 SHALL hold the pulse value until the next PD or until leaving the run states.
REQ-011 SHALL enter ERROR with err_code=2 on CALL when the stack already holds STACK_DEPTH entries; the stack is unchanged.
REQ-012 SHALL enter ERROR with err_code=3 on RET with an empty stack.
REQ-013 SHALL truncate pc increments and stack values to BRAM_ADDR_WIDTH, so pc at max+1 wraps to 0.
REQ-014 SHALL, on cfg=0 in any state, go to IDLE on the next cycle and clear these the same cycle: pc=0, stack pointer=0, pulse=0, err=0, err_code=0.
REQ-015 SHALL NOT clear tx_offset, grad_offset or C0..C3 on cfg=0.
REQ-016 SHALL treat HALTED and ERROR as sticky while cfg=1; leaving them requires cfg low then high.
REQ-017 SHALL, when cfg=1 is re-asserted from IDLE, start at pc=0.

Reset
REQ-018 SHALL, asynchronously on S_AXI_ARESETN=0, set:
- state=IDLE, pc=0, stack pointer=0;
- C0..C3=0, pulse=0, tx_offset=0, grad_offset=0;
- err=0, err_code=0, bram_porta_addr=0.
REQ-019 SHALL abort any in-flight fetch or delay on reset; the first fetch after reset release with cfg=1 is from address 0.

Structure
REQ-020 SHALL place the opcode constants, state encodings and err_code values in a shared package, pulse_sequencer_pkg.
REQ-021 SHALL implement the call stack as a sub-module, seq_call_stack, with push/pop/full/empty and depth parameter STACK_DEPTH; the FSM, counters and outputs stay in the top level.

Verification
REQ-022 SHALL cover a straight-line program: LD C0,5; TXOFFSET 0x1234; GRADOFFSET 0xBEEF; HALT -> tx_offset=0x1234, grad_offset=0xBEEF, halted=1 after 16 cycles from the first FETCH, pc=3.
REQ-023 SHALL cover a loop: LD C1,3; a: PD 0xA5 with C2=0; DEC C1; JNZ C1,a; HALT -> PD executes exactly 3 times, C1=0, halted=1.
REQ-024 SHALL cover delay timing: LD C2,10; PD 0x1; PD 0x0 -> pulse bit0 high for exactly 4+10 cycles (EXEC of the first PD to EXEC of the second).
REQ-025 SHALL cover the stack with STACK_DEPTH=2:
- CALL to a subroutine containing RET resumes at the caller +1.
- Three nested CALLs -> err=1, err_code=2.
- RET at top level -> err_code=3.
REQ-026 SHALL cover illegal opcode 0x3F -> err=1, err_code=1, pulse held.
REQ-027 SHALL cover abort and reset mid-operation:
- cfg dropped during DELAY -> IDLE next cycle, pulse=0, pc=0.
- S_AXI_ARESETN asserted mid-W1 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pulse_sequencer_pkg.sv
// Shared constants for the pulse sequencer: opcodes, FSM state encodings,
// error codes and a state-classification helper.
package pulse_sequencer_pkg;

  localparam int unsigned BramDataWidth = 64;

  // Opcodes, instr[63:58]
  localparam logic [5:0] OpNop        = 6'h00;
  localparam logic [5:0] OpDec        = 6'h01;
  localparam logic [5:0] OpInc        = 6'h02;
  localparam logic [5:0] OpLd         = 6'h03;
  localparam logic [5:0] OpTxOffset   = 6'h08;
  localparam logic [5:0] OpGradOffset = 6'h09;
  localparam logic [5:0] OpJnz        = 6'h10;
  localparam logic [5:0] OpJ          = 6'h17;
  localparam logic [5:0] OpCall       = 6'h18;
  localparam logic [5:0] OpRet        = 6'h19;
  localparam logic [5:0] OpPd         = 6'h1C;
  localparam logic [5:0] OpHalt       = 6'h1F;

  // FSM state encodings
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StW1     = 3'd2;
  localparam logic [2:0] StW2     = 3'd3;
  localparam logic [2:0] StExec   = 3'd4;
  localparam logic [2:0] StDelay  = 3'd5;
  localparam logic [2:0] StHalted = 3'd6;
  localparam logic [2:0] StError  = 3'd7;

  // err_code values
  localparam logic [1:0] ErrNone      = 2'd0;
  localparam logic [1:0] ErrIllegalOp = 2'd1;
  localparam logic [1:0] ErrOverflow  = 2'd2;
  localparam logic [1:0] ErrUnderflow = 2'd3;

  function automatic logic is_run_state(input logic [2:0] st);
    return !(st == StIdle || st == StHalted || st == StError);
  endfunction

endpackage

// File: rtl/pulse_sequencer_if.sv
// Instruction-memory port A bundle between the sequencer (master) and a
// BRAM with two-cycle read latency (slave).
//   bram_porta_clk    : port clock, driven by the sequencer
//   bram_porta_rst    : active-high port reset, driven by the sequencer
//   bram_porta_addr   : word fetch address
//   bram_porta_rddata : 64-bit instruction word
interface pulse_sequencer_if #(
  parameter int unsigned BRAM_ADDR_WIDTH = 10
);
  import pulse_sequencer_pkg::*;

  logic                       bram_porta_clk;
  logic                       bram_porta_rst;
  logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr;
  logic [BramDataWidth-1:0]   bram_porta_rddata;

  modport master (
    output bram_porta_clk,
    output bram_porta_rst,
    output bram_porta_addr,
    input  bram_porta_rddata
  );

  modport slave (
    input  bram_porta_clk,
    input  bram_porta_rst,
    input  bram_porta_addr,
    output bram_porta_rddata
  );

endinterface

// File: rtl/seq_call_stack.sv
// Return-address stack for CALL/RET.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous flush (stack pointer to zero)
//   push_i/pop_i  : ignored when full/empty respectively
//   push_data_i   : value pushed
//   top_o         : most recently pushed entry (valid when !empty_o)
//   full_o/empty_o: occupancy flags
module seq_call_stack #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned DATA_WIDTH  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic [DATA_WIDTH-1:0] top_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = $clog2(STACK_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PtrW-1:0]       sp_q, sp_d;
  logic [IdxW-1:0]       wr_idx, rd_idx;

  // sp-1 stays below 2**IdxW, so wrapping in the narrow index is exact.
  assign wr_idx  = sp_q[IdxW-1:0];
  assign rd_idx  = wr_idx - IdxW'(1);
  assign full_o  = (sp_q == PtrW'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_o   = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      sp_d = sp_q + PtrW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !clear_i) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Programmable pulse sequencer. Fetches 64-bit instructions from a BRAM
// (two-cycle read latency), runs counter/branch/call/pulse-delay opcodes.
//   S_AXI_ACLK, S_AXI_ARESETN : clock, asynchronous active-low reset
//   cfg                       : run enable; low returns to IDLE and flushes pc/stack/pulse/err
//   bram                      : instruction memory port (master side)
//   pc                        : zero-extended program counter
//   pulse                     : pulse channels, set by PD
//   tx_offset, grad_offset    : offsets set by TXOFFSET/GRADOFFSET
//   running, halted, err      : status; err_code gives the error cause
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = 10,
  parameter int unsigned PULSE_WIDTH     = 32,
  parameter int unsigned STACK_DEPTH     = 8,
  parameter int unsigned BRAM_DATA_WIDTH = 64
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   cfg,
  pulse_sequencer_if.master      bram,
  output logic [31:0]            pc,
  output logic [PULSE_WIDTH-1:0] pulse,
  output logic [15:0]            tx_offset,
  output logic [15:0]            grad_offset,
  output logic                   running,
  output logic                   halted,
  output logic                   err,
  output logic [1:0]             err_code
);

  logic [2:0]                 state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [BRAM_DATA_WIDTH-1:0] instr_q, instr_d;
  logic [3:0][31:0]           cnt_q, cnt_d;
  logic [31:0]                dly_q, dly_d;
  logic [PULSE_WIDTH-1:0]     pulse_q, pulse_d;
  logic [15:0]                tx_q, tx_d, grad_q, grad_d;
  logic [1:0]                 err_code_q, err_code_d;

  logic                       stk_push, stk_pop, stk_clear, stk_full, stk_empty;
  logic [BRAM_ADDR_WIDTH-1:0] stk_top;

  logic [5:0]                 op;
  logic [1:0]                 r;
  logic                       unused_bits;

  assign op          = instr_q[63:58];
  assign r           = instr_q[57:56];
  assign pc_inc      = pc_q + BRAM_ADDR_WIDTH'(1);
  assign unused_bits = ^instr_q[55:32];

  seq_call_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .DATA_WIDTH  (BRAM_ADDR_WIDTH)
  ) u_call_stack (
    .clk_i       (S_AXI_ACLK),
    .rst_ni      (S_AXI_ARESETN),
    .clear_i     (stk_clear),
    .push_i      (stk_push),
    .pop_i       (stk_pop),
    .push_data_i (pc_inc),
    .top_o       (stk_top),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    pulse_d    = pulse_q;
    tx_d       = tx_q;
    grad_d     = grad_q;
    err_code_d = err_code_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_clear  = 1'b0;

    if (!cfg) begin
      // Counters and offsets deliberately survive a stop/start.
      state_d    = StIdle;
      pc_d       = '0;
      pulse_d    = '0;
      err_code_d = ErrNone;
      stk_clear  = 1'b1;
    end else begin
      case (state_q)
        StIdle:  state_d = StFetch;
        StFetch: state_d = StW1;
        StW1:    state_d = StW2;
        StW2: begin
          instr_d = bram.bram_porta_rddata;
          state_d = StExec;
        end
        StExec: begin
          state_d = StFetch;
          pc_d    = pc_inc;
          case (op)
            OpNop:        ;
            OpDec:        cnt_d[r] = cnt_q[r] - 32'd1;
            OpInc:        cnt_d[r] = cnt_q[r] + 32'd1;
            OpLd:         cnt_d[r] = instr_q[31:0];
            OpTxOffset:   tx_d = instr_q[15:0];
            OpGradOffset: grad_d = instr_q[15:0];
            OpJnz: begin
              if (cnt_q[r] != 32'd0) pc_d = instr_q[BRAM_ADDR_WIDTH-1:0];
            end
            OpJ:          pc_d = instr_q[BRAM_ADDR_WIDTH-1:0];
            OpCall: begin
              if (stk_full) begin
                state_d    = StError;
                err_code_d = ErrOverflow;
                pc_d       = pc_q;
              end else begin
                stk_push = 1'b1;
                pc_d     = instr_q[BRAM_ADDR_WIDTH-1:0];
              end
            end
            OpRet: begin
              if (stk_empty) begin
                state_d    = StError;
                err_code_d = ErrUnderflow;
                pc_d       = pc_q;
              end else begin
                stk_pop = 1'b1;
                pc_d    = stk_top;
              end
            end
            OpPd: begin
              pulse_d = instr_q[PULSE_WIDTH-1:0];
              // Counter preloads Cr-1 so DELAY lasts exactly Cr cycles.
              if (cnt_q[r] != 32'd0) begin
                state_d = StDelay;
                dly_d   = cnt_q[r] - 32'd1;
              end
            end
            OpHalt: begin
              state_d = StHalted;
              pc_d    = pc_q;
            end
            default: begin
              state_d    = StError;
              err_code_d = ErrIllegalOp;
              pc_d       = pc_q;
            end
          endcase
        end
        StDelay: begin
          if (dly_q == 32'd0) state_d = StFetch;
          else                dly_d   = dly_q - 32'd1;
        end
        StHalted, StError: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      instr_q    <= '0;
      cnt_q      <= '0;
      dly_q      <= '0;
      pulse_q    <= '0;
      tx_q       <= '0;
      grad_q     <= '0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      pulse_q    <= pulse_d;
      tx_q       <= tx_d;
      grad_q     <= grad_d;
      err_code_q <= err_code_d;
    end
  end

  // pc only changes at the end of EXEC, so it is stable across FETCH/W1.
  assign bram.bram_porta_clk  = S_AXI_ACLK;
  assign bram.bram_porta_rst  = ~S_AXI_ARESETN;
  assign bram.bram_porta_addr = pc_q;

  assign pc          = 32'(pc_q);
  assign pulse       = pulse_q;
  assign tx_offset   = tx_q;
  assign grad_offset = grad_q;
  assign running     = is_run_state(state_q);
  assign halted      = (state_q == StHalted);
  assign err         = (state_q == StError);
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg;
  logic [31:0] pc;
  logic [31:0] pulse;
  logic [15:0] tx_offset, grad_offset;
  logic        running, halted, err;
  logic [1:0]  err_code;

  logic [63:0] mem [16];
  logic [63:0] rd_stage;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  pulse_sequencer_if #(.BRAM_ADDR_WIDTH(4)) bram_if ();

  pulse_sequencer #(
    .BRAM_ADDR_WIDTH (4),
    .PULSE_WIDTH     (32),
    .STACK_DEPTH     (2)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .cfg           (cfg),
    .bram          (bram_if),
    .pc            (pc),
    .pulse         (pulse),
    .tx_offset     (tx_offset),
    .grad_offset   (grad_offset),
    .running       (running),
    .halted        (halted),
    .err           (err),
    .err_code      (err_code)
  );

  // Two-cycle read latency BRAM model.
  always @(posedge clk) begin
    rd_stage                   <= mem[bram_if.bram_porta_addr];
    bram_if.bram_porta_rddata  <= rd_stage;
  end

  function automatic logic [63:0] ins(input logic [5:0] op, input logic [1:0] r,
                                      input logic [31:0] imm);
    return {op, r, 24'h0, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = ins(6'h1F, 2'd0, 32'd0);
  endtask

  // Leaves the DUT in cycle 0 (FETCH of address 0).
  task automatic start_run();
    cfg = 1'b0;
    @(posedge clk); #1;
    cfg = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_until_stop(output int cyc, output int pc3_cnt, output int hi_cnt);
    logic [31:0] prev_pc;
    cyc = 0; pc3_cnt = 0; hi_cnt = 0; prev_pc = pc;
    while (!halted && !err && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (pulse[0]) hi_cnt++;
      if (prev_pc == 32'd2 && pc == 32'd3) pc3_cnt++;
      prev_pc = pc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if ({running, halted, err, err_code} !== 5'b0)
      $display("FAIL reset_status: got %b want 00000", {running, halted, err, err_code});
    else n_pass++;
    n_total++; if ({pc, pulse, tx_offset, grad_offset} !== 96'h0)
      $display("FAIL reset_regs: got %h want 0", {pc, pulse, tx_offset, grad_offset});
    else n_pass++;
    n_total++; if (bram_if.bram_porta_rst !== 1'b1 || bram_if.bram_porta_addr !== 4'h0)
      $display("FAIL reset_bram: got rst=%b addr=%h want rst=1 addr=0",
               bram_if.bram_porta_rst, bram_if.bram_porta_addr);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (bram_if.bram_porta_rst !== 1'b0 || bram_if.bram_porta_clk !== clk)
      $display("FAIL bram_clk_rst: got rst=%b clk=%b want rst=0 clk=%b",
               bram_if.bram_porta_rst, bram_if.bram_porta_clk, clk);
    else n_pass++;
  endtask

  task automatic test_straight();
    int cyc, c3, hi;
    clear_mem();
    mem[0] = ins(6'h03, 2'd0, 32'd5);
    mem[1] = ins(6'h08, 2'd0, 32'h1234);
    mem[2] = ins(6'h09, 2'd0, 32'hBEEF);
    mem[3] = ins(6'h1F, 2'd0, 32'd0);
    start_run();
    run_until_stop(cyc, c3, hi);
    n_total++; if (cyc !== 16) $display("FAIL straight_cycles: got %0d want 16", cyc);
    else n_pass++;
    n_total++; if (tx_offset !== 16'h1234 || grad_offset !== 16'hBEEF)
      $display("FAIL straight_offsets: got %h/%h want 1234/beef", tx_offset, grad_offset);
    else n_pass++;
    n_total++; if (halted !== 1'b1 || running !== 1'b0 || pc !== 32'd3)
      $display("FAIL straight_halt: got halted=%b running=%b pc=%0d want 1 0 3",
               halted, running, pc);
    else n_pass++;
  endtask

  task automatic test_loop();
    int cyc, c3, hi;
    clear_mem();
    mem[0] = ins(6'h03, 2'd1, 32'd3);
    mem[1] = ins(6'h03, 2'd2, 32'd0);
    mem[2] = ins(6'h1C, 2'd2, 32'hA5);
    mem[3] = ins(6'h01, 2'd1, 32'd0);
    mem[4] = ins(6'h10, 2'd1, 32'd2);
    mem[5] = ins(6'h1F, 2'd0, 32'd0);
    start_run();
    run_until_stop(cyc, c3, hi);
    n_total++; if (c3 !== 3) $display("FAIL loop_pd_count: got %0d want 3", c3);
    else n_pass++;
    n_total++; if (cyc !== 48 || halted !== 1'b1 || pc !== 32'd5)
      $display("FAIL loop_end: got cyc=%0d halted=%b pc=%0d want 48 1 5", cyc, halted, pc);
    else n_pass++;
    n_total++; if (pulse !== 32'hA5) $display("FAIL loop_pulse: got %h want a5", pulse);
    else n_pass++;
  endtask

  // Second PD delays by C0, still 5 from the straight-line program.
  task automatic test_delay();
    int cyc, c3, hi;
    clear_mem();
    mem[0] = ins(6'h03, 2'd2, 32'd10);
    mem[1] = ins(6'h1C, 2'd2, 32'h1);
    mem[2] = ins(6'h1C, 2'd0, 32'h0);
    start_run();
    run_until_stop(cyc, c3, hi);
    n_total++; if (hi !== 14) $display("FAIL delay_pulse_width: got %0d want 14", hi);
    else n_pass++;
    n_total++; if (cyc !== 31) $display("FAIL delay_total_cycles: got %0d want 31", cyc);
    else n_pass++;
  endtask

  task automatic test_call_ret();
    int cyc, c3, hi;
    clear_mem();
    mem[0] = ins(6'h18, 2'd0, 32'd3);
    mem[1] = ins(6'h08, 2'd0, 32'h55);
    mem[2] = ins(6'h1F, 2'd0, 32'd0);
    mem[3] = ins(6'h09, 2'd0, 32'h77);
    mem[4] = ins(6'h19, 2'd0, 32'd0);
    start_run();
    run_until_stop(cyc, c3, hi);
    n_total++; if (cyc !== 20 || halted !== 1'b1 || pc !== 32'd2 || err !== 1'b0)
      $display("FAIL call_ret: got cyc=%0d halted=%b pc=%0d err=%b want 20 1 2 0",
               cyc, halted, pc, err);
    else n_pass++;
    n_total++; if (tx_offset !== 16'h55 || grad_offset !== 16'h77)
      $display("FAIL call_ret_offsets: got %h/%h want 0055/0077", tx_offset, grad_offset);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int cyc, c3, hi;
    clear_mem();
    mem[0] = ins(6'h18, 2'd0, 32'd1);
    mem[1] = ins(6'h18, 2'd0, 32'd2);
    mem[2] = ins(6'h18, 2'd0, 32'd3);
    start_run();
    run_until_stop(cyc, c3, hi);
    n_total++; if (cyc !== 12 || err !== 1'b1 || err_code !== 2'd2 || halted !== 1'b0)
      $display("FAIL overflow: got cyc=%0d err=%b code=%0d halted=%b want 12 1 2 0",
               cyc, err, err_code, halted);
    else n_pass++;
  endtask

  task automatic test_underflow();
    int cyc, c3, hi;
    clear_mem();
    mem[0] = ins(6'h19, 2'd0, 32'd0);
    start_run();
    run_until_stop(cyc, c3, hi);
    n_total++; if (cyc !== 4 || err !== 1'b1 || err_code !== 2'd3)
      $display("FAIL underflow: got cyc=%0d err=%b code=%0d want 4 1 3", cyc, err, err_code);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int cyc, c3, hi;
    clear_mem();
    mem[0] = ins(6'h03, 2'd3, 32'd0);
    mem[1] = ins(6'h1C, 2'd3, 32'h5A5A);
    mem[2] = ins(6'h3F, 2'd0, 32'd0);
    start_run();
    run_until_stop(cyc, c3, hi);
    n_total++; if (cyc !== 12 || err !== 1'b1 || err_code !== 2'd1 || pc !== 32'd2)
      $display("FAIL illegal: got cyc=%0d err=%b code=%0d pc=%0d want 12 1 1 2",
               cyc, err, err_code, pc);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_total++; if (err !== 1'b1 || pulse !== 32'h5A5A || running !== 1'b0)
      $display("FAIL illegal_sticky: got err=%b pulse=%h running=%b want 1 5a5a 0",
               err, pulse, running);
    else n_pass++;
    cfg = 1'b0;
    @(posedge clk); #1;
    n_total++; if (err !== 1'b0 || err_code !== 2'd0 || pulse !== 32'h0 || pc !== 32'd0)
      $display("FAIL cfg_clear: got err=%b code=%0d pulse=%h pc=%0d want 0 0 0 0",
               err, err_code, pulse, pc);
    else n_pass++;
  endtask

  task automatic test_abort();
    clear_mem();
    mem[0] = ins(6'h03, 2'd2, 32'd10);
    mem[1] = ins(6'h1C, 2'd2, 32'hFF);
    start_run();
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (pulse !== 32'hFF || running !== 1'b1 || pc !== 32'd2)
      $display("FAIL abort_pre: got pulse=%h running=%b pc=%0d want ff 1 2",
               pulse, running, pc);
    else n_pass++;
    cfg = 1'b0;
    @(posedge clk); #1;
    n_total++; if (running !== 1'b0 || pulse !== 32'h0 || pc !== 32'd0)
      $display("FAIL abort: got running=%b pulse=%h pc=%0d want 0 0 0", running, pulse, pc);
    else n_pass++;
    n_total++; if (tx_offset !== 16'h55 || grad_offset !== 16'h77)
      $display("FAIL abort_keep_offsets: got %h/%h want 0055/0077", tx_offset, grad_offset);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0]  = ins(6'h17, 2'd0, 32'd15);
    mem[15] = ins(6'h00, 2'd0, 32'd0);
    start_run();
    repeat (4) @(posedge clk);
    #1;
    n_total++; if (pc !== 32'd15) $display("FAIL wrap_jump: got pc=%0d want 15", pc);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_total++; if (pc !== 32'd0 || bram_if.bram_porta_addr !== 4'h0)
      $display("FAIL wrap_zero: got pc=%0d addr=%0d want 0 0", pc, bram_if.bram_porta_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_w1();
    int cyc, c3, hi;
    clear_mem();
    mem[0] = ins(6'h08, 2'd0, 32'h9999);
    start_run();
    @(posedge clk); #1;
    n_total++; if (running !== 1'b1) $display("FAIL w1_running: got %b want 1", running);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({running, halted, err, err_code, pc, pulse, tx_offset, grad_offset} !== 101'h0)
      $display("FAIL async_reset: got running=%b pc=%0d pulse=%h tx=%h grad=%h want all 0",
               running, pc, pulse, tx_offset, grad_offset);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_until_stop(cyc, c3, hi);
    n_total++; if (cyc !== 9 || halted !== 1'b1 || tx_offset !== 16'h9999)
      $display("FAIL post_reset_run: got cyc=%0d halted=%b tx=%h want 9 1 9999",
               cyc, halted, tx_offset);
    else n_pass++;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_straight();
    test_loop();
    test_delay();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_illegal();
    test_abort();
    test_pc_wrap();
    test_reset_mid_w1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
